// File: rtl/delta_accumulator_pkg.sv
// delta_accumulator_pkg: shared state enum plus saturating fixed-point helpers
package delta_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction
  function automatic logic signed [63:0] mult(input logic signed [63:0] a, input logic signed [63:0] b,
                                               input int w, input int f);
    return sat((a * b) >>> f, w);
  endfunction
endpackage

// File: rtl/delta_lane.sv
// delta_lane: one lane; clear/accumulate/finish strobes drive term reg, saturating acc and act multiply
module delta_lane import delta_accumulator_pkg::*; #(
  parameter int data_size = 16,
  parameter int frac_bits = 8,
  parameter int acc_size  = data_size + 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        accumulate,
  input  logic                        finish,
  input  logic signed [data_size-1:0] dense,
  input  logic signed [data_size-1:0] cost,
  input  logic signed [data_size-1:0] act,
  output logic signed [data_size-1:0] result
);
  logic signed [data_size-1:0] term;
  logic signed [acc_size-1:0]  acc;
  logic                        term_valid;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      term       <= '0;
      term_valid <= 1'b0;
      acc        <= '0;
      result     <= '0;
    end else begin
      term_valid <= accumulate;
      if (accumulate) term <= data_size'(mult(64'(dense), 64'(cost), data_size, frac_bits));
      if (term_valid) acc <= acc_size'(sat(64'(acc) + 64'(term), acc_size));
      if (finish) result <= data_size'(mult(sat(64'(acc), data_size), 64'(act), data_size, frac_bits));
    end
  end
endmodule

// File: rtl/delta_accumulator.sv
// delta_accumulator: backprop delta engine, delta_prev[i] = act'[i] * sum_k W[k][i]*delta_next[k], valid/ready in and out
module delta_accumulator import delta_accumulator_pkg::*; #(
  parameter int data_size = 16,
  parameter int frac_bits = 8,
  parameter int size      = 3,
  parameter int max_rows  = 16,
  parameter int acc_size  = data_size + 8,
  parameter int rw        = $clog2(max_rows + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_new_layer,
  input  logic [data_size*size-1:0] diff_act,
  input  logic [rw-1:0]             row_count,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_size*size-1:0] diff_dense,
  input  logic [data_size-1:0]      diff_cost,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_size*size-1:0] diff_z_to_z
);
  state_t                    state;
  logic                      rdy_q;
  logic [rw-1:0]             rows_seen;
  logic [rw-1:0]             row_cnt;
  logic [1:0]                dcnt;
  logic [data_size*size-1:0] act_reg;
  logic [data_size*size-1:0] fin;
  logic [rw-1:0]             clamped;
  logic                      accept;
  logic                      last;
  logic                      finish;
  // the start cycle masks the registered ready so a beat there is never taken
  assign in_ready = rdy_q & ~start_new_layer;
  assign accept   = in_valid & in_ready;
  assign last     = accept && (rows_seen + rw'(1) == row_cnt);
  assign clamped  = row_count > rw'(max_rows) ? rw'(max_rows) : row_count;
  // dcnt==1 is the cycle where the final accumulator value is present
  assign finish   = state == DRAIN && dcnt == 2'd1;
  for (genvar i = 0; i < size; i++) begin : g_lane
    delta_lane #(.data_size(data_size), .frac_bits(frac_bits), .acc_size(acc_size)) u_lane (
      .clk(clk),
      .reset(reset),
      .clear(start_new_layer),
      .accumulate(accept),
      .finish(finish),
      .dense(diff_dense[data_size*(size-i)-1 -: data_size]),
      .cost(diff_cost),
      .act(act_reg[data_size*(size-i)-1 -: data_size]),
      .result(fin[data_size*(size-i)-1 -: data_size])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rdy_q       <= 1'b0;
      out_valid   <= 1'b0;
      diff_z_to_z <= '0;
      act_reg     <= '0;
      rows_seen   <= '0;
      row_cnt     <= '0;
      dcnt        <= '0;
    end else if (start_new_layer) begin
      act_reg   <= diff_act;
      row_cnt   <= clamped;
      rows_seen <= '0;
      out_valid <= 1'b0;
      rdy_q     <= clamped != '0;
      state     <= clamped == '0 ? DRAIN : ACCUM;
      dcnt      <= 2'd1;
    end else begin
      unique case (state)
        ACCUM: if (accept) begin
          rows_seen <= rows_seen + rw'(1);
          if (last) begin
            state <= DRAIN;
            rdy_q <= 1'b0;
            dcnt  <= 2'd2;
          end
        end
        DRAIN: if (dcnt == 2'd0) begin
          state       <= OUTPUT;
          out_valid   <= 1'b1;
          diff_z_to_z <= fin;
        end else dcnt <= dcnt - 2'd1;
        OUTPUT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_delta_accumulator.sv
// tb_delta_accumulator: randomized scoreboard bench against an arithmetic reference model
module tb_delta_accumulator;
  logic        clk = 0;
  logic        reset;
  logic        start_new_layer;
  logic [47:0] diff_act;
  logic [4:0]  row_count;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] diff_dense;
  logic [15:0] diff_cost;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] diff_z_to_z;
  delta_accumulator dut (
    .clk(clk), .reset(reset), .start_new_layer(start_new_layer), .diff_act(diff_act),
    .row_count(row_count), .in_valid(in_valid), .in_ready(in_ready), .diff_dense(diff_dense),
    .diff_cost(diff_cost), .out_valid(out_valid), .out_ready(out_ready), .diff_z_to_z(diff_z_to_z)
  );
  always #5 clk = ~clk;
  int          tests = 0, fails = 0;
  int          edge_cnt = 0, start_edge = 0, last_edge = 0;
  int          dense[32][3];
  int          cost[32];
  int          act[3];
  logic [47:0] exp_q[$];
  always @(posedge clk) edge_cnt++;
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string name, input longint a, input longint e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  always @(negedge clk) if (out_valid && out_ready) begin
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL result: unexpected output %h", diff_z_to_z);
    end else begin
      logic [47:0] e;
      e = exp_q.pop_front();
      if (diff_z_to_z !== e) begin
        fails++;
        $display("FAIL result: got %h expected %h", diff_z_to_z, e);
      end
    end
  end
  function automatic longint msat(input longint v, input int w);
    longint hi;
    hi = (longint'(1) << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction
  function automatic longint mmul(input longint a, input longint b);
    longint p, q;
    p = a * b;
    q = p / 256;
    if (p < 0 && p % 256 != 0) q = q - 1;
    return msat(q, 16);
  endfunction
  function automatic logic [47:0] model(input int eff);
    logic [47:0] r;
    longint      s;
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int k = 0; k < eff; k++) s = msat(s + mmul(dense[k][i], cost[k]), 24);
      r[47-16*i -: 16] = 16'(mmul(msat(s, 16), act[i]));
    end
    return r;
  endfunction
  function automatic logic [47:0] pack(input int k);
    return {16'(dense[k][0]), 16'(dense[k][1]), 16'(dense[k][2])};
  endfunction
  task automatic rand_rows(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 3; i++) dense[k][i] = int'($urandom_range(2048)) - 1024;
      cost[k] = int'($urandom_range(2048)) - 1024;
    end
    for (int i = 0; i < 3; i++) act[i] = int'($urandom_range(1024)) - 512;
  endtask
  task automatic start_layer(input int rc);
    start_new_layer = 1;
    diff_act = {16'(act[0]), 16'(act[1]), 16'(act[2])};
    row_count = 5'(rc);
    @(negedge clk);
    check("start_no_ready", in_ready, 0);
    start_edge = edge_cnt + 1;
    @(posedge clk); #1;
    start_new_layer = 0;
  endtask
  task automatic feed(input int n, input int gap, output int got);
    int  c;
    bit  stop;
    got = 0; c = 0; stop = 0;
    while (got < n && c < 300 && !stop) begin
      in_valid = $urandom_range(99) >= gap;
      diff_dense = pack(got);
      diff_cost = 16'(cost[got]);
      @(negedge clk);
      if (in_valid && in_ready) begin
        got++;
        last_edge = edge_cnt + 1;
      end else if (in_valid) stop = 1;
      @(posedge clk); #1;
      c++;
    end
    in_valid = 0;
  endtask
  task automatic finish_layer(input int ref_e, input int lat, input int hold);
    int          n;
    logic [47:0] snap;
    bit          ok;
    out_ready = hold == 0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", edge_cnt - ref_e, lat);
    if (hold > 0) begin
      snap = diff_z_to_z;
      ok = 1;
      repeat (hold) begin
        if (!out_valid || diff_z_to_z !== snap || in_ready) ok = 0;
        @(negedge clk);
      end
      check("hold_stable", ok, 1);
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    check("idle_after", out_valid, 0);
    @(posedge clk); #1;
  endtask
  task automatic layer(input int rc, input int gap, input int hold);
    int eff, got;
    eff = rc > 16 ? 16 : rc;
    exp_q.push_back(model(eff));
    start_layer(rc);
    if (eff > 0) begin
      feed(rc, gap, got);
      check("beats", got, eff);
      finish_layer(last_edge, 3, hold);
    end else finish_layer(start_edge, 2, hold);
  endtask
  initial begin
    int          got;
    bit          ok;
    logic [47:0] save;
    reset = 1; start_new_layer = 0; diff_act = 0; row_count = 0; in_valid = 0;
    diff_dense = 0; diff_cost = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_data", diff_z_to_z, 0);
    @(posedge clk); #1;
    reset = 0;
    act = '{256, 128, 512};
    dense[0] = '{256, 256, 256}; cost[0] = 256;
    dense[1] = '{128, 512, -256}; cost[1] = 512;
    layer(2, 0, 0);
    check("basic_value", diff_z_to_z, 48'h0200_0280_FE00);
    layer(2, 0, 10);
    check("backpressure_value", diff_z_to_z, 48'h0200_0280_FE00);
    act = '{256, 256, 256};
    for (int k = 0; k < 16; k++) begin
      dense[k] = '{32512, 32512, 32512};
      cost[k] = 32512;
    end
    layer(16, 0, 0);
    check("sat_pos", diff_z_to_z, 48'h7FFF_7FFF_7FFF);
    for (int k = 0; k < 16; k++) cost[k] = -32512;
    layer(16, 20, 0);
    check("sat_neg", diff_z_to_z, 48'h8000_8000_8000);
    rand_rows(20);
    layer(0, 0, 0);
    check("zero_rows", diff_z_to_z, 0);
    rand_rows(20);
    layer(20, 0, 0);
    rand_rows(3);
    start_layer(3);
    feed(1, 0, got);
    in_valid = 1;
    diff_dense = pack(1);
    act = '{256, 256, 256};
    start_layer(1);
    in_valid = 0;
    dense[0] = '{64, 64, 64}; cost[0] = 256;
    exp_q.push_back(model(1));
    feed(1, 0, got);
    check("abort_beats", got, 1);
    finish_layer(last_edge, 3, 0);
    check("abort_value", diff_z_to_z, 48'h0040_0040_0040);
    rand_rows(8);
    layer(8, 0, 0);
    save = diff_z_to_z;
    layer(8, 50, 0);
    check("stall_same", diff_z_to_z, save);
    rand_rows(3);
    start_layer(3);
    feed(2, 0, got);
    in_valid = 1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_data", diff_z_to_z, 0);
    ok = 1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || in_ready) ok = 0;
    end
    check("midrst_quiet", ok, 1);
    in_valid = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 6; t++) begin
      rand_rows(16);
      layer(int'($urandom_range(16, 1)), int'($urandom_range(50)), t % 2 == 0 ? 0 : 3);
    end
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/delta_accumulator.md
# delta_accumulator

Parametrised backprop delta engine for one layer. It computes delta_prev[i] = act'[i] · Σ_k W[k][i] · delta_next[k] over a variable number of weight rows, using signed fixed-point arithmetic with saturation. Inputs arrive as a valid/ready stream and the result leaves through an output handshake. It sits in the backprop stack between the cost/derivative stages and the weight-gradient stage. It supersedes the fixed-size, handshake-less z-to-z path with configurable lanes, depth, fraction width and flow control.

## Interface
- data_size, 16: signed lane width (two's complement).
- frac_bits, 8: fractional bits; 1.0 = 1 << frac_bits.
- size, 3: lanes (output vector length, row width).
- max_rows, 16: maximum rows per layer.
- acc_size, data_size+8: accumulator width per lane.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start_new_layer  in  1  one-cycle pulse: latch diff_act and row_count, clear accumulators, begin layer.
- diff_act  in  data_size*size  activation derivatives; lane i = bits [data_size*(size-i)-1 -: data_size].
- row_count  in  $clog2(max_rows+1)  rows for this layer, sampled with start_new_layer; values above max_rows clamp to max_rows.
- in_valid  in  1  row beat valid.
- in_ready  out  1  engine accepts a row.
- diff_dense  in  data_size*size  weight row k, same lane packing.
- diff_cost  in  data_size  delta_next[k] for row k.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts the result.
- diff_z_to_z  out  data_size*size  delta_prev, same lane packing.

## Operation
- mult(a,b) = sat_data((a*b) >>> frac_bits), using a full 2*data_size product and arithmetic shift (floor).
- sat_data clamps to [-2^(data_size-1), 2^(data_size-1)-1]. sat_acc does the same at acc_size.
- States:
  - IDLE: in_ready=0, out_valid=0.
  - ACCUM: in_ready=1.
  - DRAIN: pipeline flush, in_ready=0.
  - OUTPUT: out_valid=1.
- Transitions:
  - start_new_layer moves any state to ACCUM. If the latched row_count is 0, it moves to DRAIN instead.
  - In ACCUM, the accepted beat that brings rows_seen to row_count moves the engine to DRAIN.
  - DRAIN moves to OUTPUT after the pipeline empties.
  - OUTPUT moves to IDLE on out_ready.
- Per accepted beat, for every lane i: term[i] = mult(diff_dense[i], diff_cost), then acc[i] = sat_acc(acc[i] + sign-extend(term[i])).
- On drain completion: diff_z_to_z[i] = mult(sat_data(acc[i]), act_reg[i]).
- start_new_layer has priority over every other event in the same cycle:
  - it aborts an accumulation in progress;
  - it discards an unaccepted result;
  - a beat presented in that cycle is not accepted (in_ready is 0 during the start cycle).
- The output register holds its value and out_valid stays high until out_ready. diff_z_to_z is stable while out_valid=1.
- in_valid or out_ready outside the relevant state are ignored.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, diff_z_to_z=0, accumulators=0, act_reg=0, rows_seen=0.
- in_ready is a registered state decode. It is high from the cycle after the start pulse.
- Stage 1: the term is registered at the accepting edge.
- Stage 2: the accumulator is updated at the next edge.
- Stage 3: the output product is registered one edge later.
- out_valid rises 3 edges after the edge that accepts the last beat.
- For row_count=0, out_valid rises 2 edges after the start edge, with result 0.
- Back-to-back beats are sustained at 1 row/cycle, with no bubbles required.
- A reset asserted mid-layer takes effect at the next edge. The pipeline contents are lost.

## Structure
- Shared package (extends gdo) holds:
  - the mult and sat functions, parametrised by width and frac_bits;
  - the state enum IDLE/ACCUM/DRAIN/OUTPUT.
- Top module holds the FSM, the rows_seen counter, act_reg, the handshake and the output register.
- Sub-module delta_lane is instantiated size times. It contains the term register, the saturating accumulator and the final act multiply, with clear, accumulate and finish strobes driven from the FSM.

## Test plan
All scenarios use data_size=16, frac_bits=8 and size=3; 1.0 = 0x0100.
- Basic: act=(1.0,0.5,2.0), row_count=2, rows (1.0,1.0,1.0)·cost 1.0 and (0.5,2.0,-1.0)·cost 2.0, out_ready=1 → diff_z_to_z=(2.0,2.5,-2.0)=(0x0200,0x0280,0xFE00), out_valid 3 edges after the last beat.
- Backpressure: same layer with out_ready=0 for 10 cycles → out_valid and data stable for all 10 cycles; IDLE the cycle after out_ready=1; in_ready stays 0 throughout.
- Saturation: act=1.0 in all lanes, row_count=16, rows 127.0 (0x7F00)·cost 127.0 → every lane 0x7FFF; negated cost → 0x8000.
- Zero rows: row_count=0 → out_valid 2 edges after start, result 0; row_count=20 → exactly 16 beats accepted.
- Abort: start_new_layer after 1 of 3 beats with new act=1.0, row_count=1, row (0.25,0.25,0.25)·1.0 → result (0x0040,0x0040,0x0040), no contamination from the aborted row.
- Reset mid-layer and in_valid stalls: random in_valid gaps give results identical to the no-gap run; reset during ACCUM → all outputs 0, no out_valid until the next start.
